// File: rtl/uart_loader_pkg.sv
// Shared command codes, reply bytes and FSM state encoding for the UART bus loader.
package uart_loader_pkg;

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_H    = 8'h48;
  localparam logic [7:0] CMD_G    = 8'h47;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_W_DATA,
    S_W_BUS,
    S_R_BUS,
    S_R_WAIT,
    S_R_SEND,
    S_ACK,
    S_NAK
  } state_t;

  // Lane 0 is bits 7:0.
  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-byte watchdog: loadable down-counter, counts only while enabled.
// expire is high while enabled with the count exhausted; load takes priority.
module loader_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= load_value;
    end else if (load) begin
      cnt <= load_value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_loader.sv
// Host-side bus initiator: parses byte commands from the UART RX FIFO into RAM writes/reads.
// Pops at most one byte per two cycles; TX replies wait on tx_full without timing out.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [23:0] TIMEOUT       = 24'd1000000,
  parameter logic        HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  tx_data,
  output logic        cpu_hold,
  output logic [29:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  we,
  output logic        re,
  input  logic [31:0] rdata
);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [7:0]  rbyte_q, rbyte_d;
  logic        hold_q, hold_d;
  logic        skip_q;

  logic        fetch_state, count_en, pop, expire, push;
  logic [7:0]  tx_byte;
  logic [3:0]  we_c;
  logic        re_c;

  assign fetch_state = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                       (state_q == S_LEN)  || (state_q == S_W_DATA);
  assign count_en    = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_W_DATA);
  // skip_q blanks the cycle after a pop while the FIFO advances its read pointer.
  assign pop         = fetch_state && !rx_empty && !skip_q && !expire;

  loader_timer #(.W(24)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (pop),
    .load_value (TIMEOUT),
    .en         (count_en),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      cmd_q   <= '0;
      wbyte_q <= '0;
      rbyte_q <= '0;
      hold_q  <= HOLD_AT_RESET;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      wbyte_q <= wbyte_d;
      rbyte_q <= rbyte_d;
      hold_q  <= hold_d;
      skip_q  <= pop;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    n_d     = n_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    wbyte_d = wbyte_q;
    rbyte_d = rbyte_q;
    hold_d  = hold_q;
    push    = 1'b0;
    tx_byte = 8'h00;
    we_c    = 4'b0000;
    re_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = rx_data;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        idx_d = 2'd0;
        n_d   = 16'd0;
        case (cmd_q)
          CMD_W, CMD_R: state_d = hold_q ? S_ADDR : S_NAK;
          CMD_H: begin
            hold_d  = 1'b1;
            state_d = S_ACK;
          end
          CMD_G: begin
            hold_d  = 1'b0;
            state_d = S_ACK;
          end
          default: state_d = S_NAK;
        endcase
      end
      S_ADDR: begin
        if (expire) begin
          state_d = S_IDLE;
        end else if (pop) begin
          a_d[8*idx_q +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (expire) begin
          state_d = S_IDLE;
        end else if (pop) begin
          if (idx_q == 2'd0) begin
            n_d[7:0] = rx_data;
            idx_d    = 2'd1;
          end else begin
            n_d[15:8] = rx_data;
            if ({rx_data, n_q[7:0]} == 16'd0) state_d = S_ACK;
            else if (cmd_q == CMD_W)          state_d = S_W_DATA;
            else                              state_d = S_R_BUS;
          end
        end
      end
      S_W_DATA: begin
        if (expire) begin
          state_d = S_IDLE;
        end else if (pop) begin
          wbyte_d = rx_data;
          state_d = S_W_BUS;
        end
      end
      S_W_BUS: begin
        we_c    = 4'b0001 << a_q[1:0];
        a_d     = a_q + 32'd1;
        n_d     = n_q - 16'd1;
        state_d = (n_q == 16'd1) ? S_ACK : S_W_DATA;
      end
      S_R_BUS: begin
        re_c    = 1'b1;
        state_d = S_R_WAIT;
      end
      S_R_WAIT: begin
        rbyte_d = lane_sel(rdata, a_q[1:0]);
        state_d = S_R_SEND;
      end
      S_R_SEND: begin
        tx_byte = rbyte_q;
        if (!tx_full) begin
          push    = 1'b1;
          a_d     = a_q + 32'd1;
          n_d     = n_q - 16'd1;
          state_d = (n_q == 16'd1) ? S_ACK : S_R_BUS;
        end
      end
      S_ACK: begin
        tx_byte = ACK_BYTE;
        if (!tx_full) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NAK: begin
        tx_byte = NAK_BYTE;
        if (!tx_full) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_uart  = pop && !reset;
  assign wr_uart  = push && !reset;
  assign tx_data  = tx_byte;
  assign we       = we_c;
  assign re       = re_c;
  assign addr     = a_q[31:2];
  assign wdata    = {4{wbyte_q}};
  assign cpu_hold = hold_q;

endmodule
